// File: rtl/servo_pwm_decoder.sv
// Servo PWM receive decoder: measures pulse width and frame period
// in microsecond ticks and reports position, strobes and link health.
module servo_pwm_decoder #(
  parameter int TICK_DIV    = 100,
  parameter int PW_MIN_US   = 500,
  parameter int PW_MAX_US   = 2500,
  parameter int PERIOD_US   = 20000,
  parameter int PERIOD_TOL  = 2000,
  parameter int LOCK_FRAMES = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PWM_IN,
  output logic [15:0] PULSE_US,
  output logic [11:0] POSITION,
  output logic        FRAME_VALID,
  output logic        FRAME_ERR,
  output logic        TIMEOUT,
  output logic        LOCKED
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0] W_MIN  = 16'(PW_MIN_US);
  localparam logic [15:0] W_MAX  = 16'(PW_MAX_US);
  localparam logic [15:0] PER_LO = 16'(PERIOD_US - PERIOD_TOL);
  localparam logic [15:0] PER_HI = 16'(PERIOD_US + PERIOD_TOL);
  localparam logic [2:0]  LOCK_N = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    S_WAIT,
    S_HIGH,
    S_LOW
  } state_t;

  state_t        state;
  logic          sync1;
  logic          sync2;
  logic          sync3;
  logic          rise_q;
  logic          fall_q;
  logic [PW-1:0] presc;
  logic          tick;
  logic [15:0]   hi_cnt;
  logic [15:0]   per_cnt;
  logic [15:0]   hi_next;
  logic [15:0]   per_next;
  logic [15:0]   width_q;
  logic [2:0]    good_cnt;
  logic [2:0]    good_next;
  logic          width_ok;
  logic          period_ok;
  logic          over;

  // Two-flop synchroniser plus one history flop; left unreset so a
  // reset taken mid-pulse does not fabricate an edge afterwards.
  always_ff @(posedge CLK) begin
    sync1 <= PWM_IN;
    sync2 <= sync1;
    sync3 <= sync2;
  end

  // Registered edge strobes; both edges see the same delay.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= sync2 & ~sync3;
      fall_q <= ~sync2 & sync3;
    end
  end

  // Microsecond prescaler, realigned to every rising edge.
  always_ff @(posedge CLK) begin
    if (RST || rise_q) begin
      presc <= '0;
    end else if (presc == PRE_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = (presc == PRE_LAST);

  // Next counter values include the tick of the current cycle so the
  // edge cycle itself is counted: width = floor(cycles/TICK_DIV).
  always_comb begin
    hi_next  = hi_cnt;
    per_next = per_cnt;
    if (hi_cnt != 16'hFFFF) begin
      hi_next = hi_cnt + 16'(tick);
    end
    if (per_cnt != 16'hFFFF) begin
      per_next = per_cnt + 16'(tick);
    end
  end

  assign width_ok  = (width_q >= W_MIN) && (width_q <= W_MAX);
  assign period_ok = (per_next >= PER_LO) && (per_next <= PER_HI);
  assign over      = (per_cnt > PER_HI);
  assign good_next = (good_cnt >= LOCK_N) ? LOCK_N : good_cnt + 3'd1;

  // Frame FSM with registered results, strobes and health flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_WAIT;
      hi_cnt      <= '0;
      per_cnt     <= '0;
      width_q     <= '0;
      good_cnt    <= '0;
      PULSE_US    <= '0;
      POSITION    <= '0;
      FRAME_VALID <= 1'b0;
      FRAME_ERR   <= 1'b0;
      TIMEOUT     <= 1'b0;
      LOCKED      <= 1'b0;
    end else begin
      FRAME_VALID <= 1'b0;
      FRAME_ERR   <= 1'b0;
      unique case (state)
        S_WAIT: begin
          if (rise_q) begin
            hi_cnt  <= '0;
            per_cnt <= '0;
            TIMEOUT <= 1'b0;
            state   <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (over) begin
            TIMEOUT  <= 1'b1;
            LOCKED   <= 1'b0;
            good_cnt <= '0;
            state    <= S_WAIT;
          end else begin
            hi_cnt  <= hi_next;
            per_cnt <= per_next;
            if (fall_q) begin
              width_q <= hi_next;
              state   <= S_LOW;
            end
          end
        end
        S_LOW: begin
          if (over) begin
            TIMEOUT  <= 1'b1;
            LOCKED   <= 1'b0;
            good_cnt <= '0;
            state    <= S_WAIT;
          end else if (rise_q) begin
            if (width_ok && period_ok) begin
              PULSE_US    <= width_q;
              POSITION    <= 12'(width_q - W_MIN);
              FRAME_VALID <= 1'b1;
              good_cnt    <= good_next;
              LOCKED      <= (good_next == LOCK_N);
            end else begin
              FRAME_ERR <= 1'b1;
              good_cnt  <= '0;
              LOCKED    <= 1'b0;
            end
            hi_cnt  <= '0;
            per_cnt <= '0;
            state   <= S_HIGH;
          end else begin
            per_cnt <= per_next;
          end
        end
        default: begin
          state <= S_WAIT;
        end
      endcase
    end
  end

endmodule
